// File: rtl/tick_arb_pkg.sv
// Shared types and helpers for the tick/slot arbiter.
// Contents:
//   state_t      FSM encoding (IDLE / RUN / DRAIN)
//   DEF_NREQ     default number of requesters
//   DEF_CNT_W    default divider width
//   pick_t       result of a round-robin search (valid + index)
//   rr_search()  round-robin priority search over up to MAX_NREQ requesters
package tick_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_CNT_W = 4;
    localparam int MAX_NREQ  = 16;
    localparam int IDX_W     = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scan req starting at ptr, ascending, wrapping at nreq-1 -> 0.
    // ptr is always < nreq, so a single conditional subtract performs the wrap
    // and handles non-power-of-two requester counts.
    function automatic pick_t rr_search(input logic [MAX_NREQ-1:0] req,
                                        input logic [IDX_W-1:0]    ptr,
                                        input int                  nreq);
        pick_t res;
        int    cand;
        res = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (i < nreq) begin
                cand = int'(ptr) + i;
                if (cand >= nreq) begin
                    cand = cand - nreq;
                end
                if (!res.valid && req[cand[IDX_W-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = cand[IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_slot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req    per-requester request vector
//   ptr    highest-priority index for this search
//   gnt    one-hot grant (all zero when nothing requested)
//   idx    index of the granted requester
//   valid  a requester was found
module rr_pick
    import tick_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    pick_t sel;

    always_comb begin
        sel   = rr_search(MAX_NREQ'(req), IDX_W'(ptr), NREQ);
        valid = sel.valid;
        idx   = sel.idx[PTR_W-1:0];
        gnt   = sel.valid ? (NREQ'(1) << sel.idx) : '0;
    end

endmodule

// File: rtl/tick_slot_arbiter.sv
// tick_slot_arbiter: programmable clock-enable generator whose every tick is
// handed to one requester by round-robin arbitration.
// Ports:
//   iClk   system clock (rising edge)
//   iRst   synchronous active-high reset
//   iEn    run request (level)
//   iDiv   period minus one; sampled at IDLE->RUN and at each tick
//   iReq   per-requester slot requests
//   oTick  one-cycle pulse at the end of each period
//   oGnt   one-hot grant, only during the oTick cycle
//   oBusy  high whenever not IDLE
//
// state    | meaning
// ST_IDLE  | stopped, counter parked at 0, no ticks
// ST_RUN   | counting periods and ticking while iEn is high
// ST_DRAIN | iEn dropped mid-period; finish the period with one last tick
module tick_slot_arbiter
    import tick_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int CNT_W = DEF_CNT_W,
    parameter int PTR_W = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic [CNT_W-1:0] iDiv,
    input  logic [NREQ-1:0]  iReq,
    output logic             oTick,
    output logic [NREQ-1:0]  oGnt,
    output logic             oBusy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rCnt, cnt_nxt;
    logic [CNT_W-1:0] rDiv, div_nxt;
    logic [PTR_W-1:0] rPtr, ptr_nxt;
    logic             tick;
    logic [NREQ-1:0]  pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (iReq),
        .ptr   (rPtr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Tick decoded purely from registers so it never depends on iReq.
    assign tick  = (state != ST_IDLE) && (rCnt == rDiv);
    assign oTick = tick;
    assign oGnt  = tick ? pick_gnt : '0;
    assign oBusy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = rCnt;
        div_nxt   = rDiv;
        ptr_nxt   = rPtr;

        if (tick && pick_valid) begin
            ptr_nxt = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (iEn) begin
                    div_nxt   = iDiv;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (tick) begin
                    cnt_nxt   = '0;
                    div_nxt   = iDiv;
                    state_nxt = iEn ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_nxt   = rCnt + 1'b1;
                    // DRAIN and RUN count identically; only the label changes,
                    // so re-asserting iEn in DRAIN leaves rCnt untouched.
                    state_nxt = iEn ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
            rCnt  <= '0;
            rDiv  <= '0;
            rPtr  <= '0;
        end else begin
            state <= state_nxt;
            rCnt  <= cnt_nxt;
            rDiv  <= div_nxt;
            rPtr  <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_tick_slot_arbiter.sv
// Testbench for tick_slot_arbiter: directed scenarios plus randomized traffic,
// all compared against a period/pointer reference model kept here.
module tb_tick_slot_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] dv;
    logic [NREQ-1:0]  req;
    logic             tick;
    logic [NREQ-1:0]  gnt;
    logic             busy;

    always #5 clk = ~clk;

    tick_slot_arbiter #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) dut (
        .iClk  (clk),
        .iRst  (rst),
        .iEn   (en),
        .iDiv  (dv),
        .iReq  (req),
        .oTick (tick),
        .oGnt  (gnt),
        .oBusy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: running flag, cycles elapsed in current period,
    // period length, next-priority requester
    int m_busy, m_elapsed, m_len, m_ptr;

    logic            obs_tick;
    logic [NREQ-1:0] obs_gnt;
    logic            obs_busy;
    logic [NREQ-1:0] gq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs are already driven by the caller.
    task automatic step();
        int              e_tick;
        int              nptr;
        int              j;
        logic [NREQ-1:0] e_gnt;
        #1;
        e_tick = (m_busy != 0 && m_elapsed + 1 == m_len) ? 1 : 0;
        e_gnt  = '0;
        nptr   = m_ptr;
        if (e_tick != 0) begin
            for (int i = 0; i < NREQ; i++) begin
                j = (m_ptr + i) % NREQ;
                if (req[j] && e_gnt == '0) begin
                    e_gnt = NREQ'(1) << j;
                    nptr  = (j + 1) % NREQ;
                end
            end
        end
        chk("tick", 32'(tick), 32'(e_tick));
        chk("gnt",  32'(gnt),  32'(e_gnt));
        chk("busy", 32'(busy), 32'(m_busy));
        obs_tick = tick;
        obs_gnt  = gnt;
        obs_busy = busy;
        if (rst) begin
            m_busy = 0; m_elapsed = 0; m_len = 1; m_ptr = 0;
        end else if (m_busy == 0) begin
            if (en) begin
                m_busy = 1; m_elapsed = 0; m_len = int'(dv) + 1;
            end
        end else if (e_tick != 0) begin
            m_ptr = nptr; m_elapsed = 0; m_len = int'(dv) + 1;
            if (!en) m_busy = 0;
        end else begin
            m_elapsed++;
        end
        @(negedge clk);
    endtask

    task automatic grab(input int n);
        int got = 0;
        int budget = 0;
        gq.delete();
        while (got < n && budget < 64) begin
            step();
            budget++;
            if (obs_tick) begin
                gq.push_back(obs_gnt);
                got++;
            end
        end
        chk("grab_count", 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int               mask;
        int               cnt;
        int               n;
        int               t1;
        int               t2;
        int               s;
        logic [NREQ-1:0]  exp_rr[8];

        rst = 1'b1; en = 1'b0; dv = '0; req = '0;
        m_busy = 0; m_elapsed = 0; m_len = 1; m_ptr = 0;
        @(negedge clk);
        @(negedge clk);

        // reset held, then idle
        for (int k = 0; k < 3; k++) step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // period with iDiv=3
        dv = 4'd3; en = 1'b1; mask = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            if (obs_tick) mask |= (1 << k);
        end
        chk("period_mask", 32'(mask), 32'h1110);

        // iDiv=0 takes effect after the next tick, then ticks every cycle
        dv = 4'd0; cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_tick) cnt++;
        end
        chk("div0_ticks", 32'(cnt), 32'd5);
        en = 1'b0; n = 0;
        while (busy && n < 20) begin step(); n++; end
        chk("stop_idle", 32'(busy), 32'd0);

        // round-robin
        do_reset();
        dv = 4'd1; req = 4'b1111; en = 1'b1;
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0010};
        grab(5);
        for (int k = 0; k < 5 && k < gq.size(); k++) chk("rr_all", 32'(gq[k]), 32'(exp_rr[k]));
        req = 4'b1010;
        grab(3);
        for (int k = 0; k < 3 && k < gq.size(); k++) chk("rr_1010", 32'(gq[k]), 32'(exp_rr[5 + k]));

        // drain: drop iEn at rCnt=2 with iDiv=7
        do_reset();
        dv = 4'd7; en = 1'b1; req = 4'b0100;
        step(); step(); step();
        en = 1'b0; n = 0;
        do begin step(); n++; end while (!obs_tick && n < 20);
        chk("drain_gap", 32'(n), 32'd6);
        chk("drain_gnt", 32'(obs_gnt), 32'(4'b0100));
        step();
        chk("drain_busy", 32'(obs_busy), 32'd0);

        // mid-period iDiv change 3 -> 9 at rCnt=1
        do_reset();
        dv = 4'd3; en = 1'b1; req = '0;
        step(); step();
        dv = 4'd9; s = 2; t1 = -1; t2 = -1;
        while (t2 < 0 && s < 40) begin
            step();
            if (obs_tick) begin
                if (t1 < 0) t1 = s; else t2 = s;
            end
            s++;
        end
        chk("mid_div_t1", 32'(t1), 32'd4);
        chk("mid_div_t2", 32'(t2), 32'd14);

        // reset mid-operation at rCnt=5
        do_reset();
        dv = 4'd7; en = 1'b1; req = 4'b1111;
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b0;
        step();
        chk("rst_tick", 32'(obs_tick), 32'd0);
        chk("rst_gnt",  32'(obs_gnt),  32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        dv = 4'd2; en = 1'b1;
        grab(1);
        if (gq.size() > 0) chk("rst_first_gnt", 32'(gq[0]), 32'(4'b0001));

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) dv = CNT_W'($urandom_range(0, 15));
            req = NREQ'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
